// File: rtl/vr_buffered_slave.sv
// vr_buffered_slave: valid/ready sink that buffers words in a DEPTH-entry FIFO and re-emits them downstream.
// Optional `STALL_INJECT_EN adds LFSR-driven backpressure on ready.
module vr_buffered_slave #(
  parameter int          DATA_WIDTH = 8,
  parameter int          DEPTH      = 4,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic                    ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             recv_count
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            LW       = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vr_buffered_slave: DEPTH must be a power of two >= 2");
  end
  if (STALL_SEED == 16'h0000) begin : g_bad_seed
    $error("vr_buffered_slave: STALL_SEED must be nonzero");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         lvl_q;
  logic [15:0]           cnt_q;
  logic                  init_done;
  logic                  stall;
  logic                  push, pop;

  // ready depends only on registers, so valid never loops back into it
  assign ready      = init_done && (lvl_q != FULL_LVL) && !stall;
  assign out_valid  = (lvl_q != '0);
  assign out_data   = mem[rd_ptr];
  assign push       = valid && ready;
  assign pop        = out_valid && out_ready;
  assign level      = lvl_q;
  assign recv_count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lvl_q     <= '0;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        cnt_q  <= cnt_q + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      lvl_q <= lvl_q + LW'(1);
      else if (pop && !push) lvl_q <= lvl_q - LW'(1);
    end
  end

  // storage is not cleared on reset; out_data is don't-care while empty
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= data;
  end

`ifdef STALL_INJECT_EN
  logic [15:0] lfsr;

  // Fibonacci taps 16,14,13,11
  always_ff @(posedge clk) begin
    if (rst) lfsr <= STALL_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[3:0] == 4'h0);
`else
  assign stall = 1'b0;
`endif

endmodule
